// File: rtl/os_array_feeder.sv
// Operand feeder for an output-stationary systolic array: clears the result
// cache, streams k_len A/B beats through per-lane skew lines, then flushes.
module os_array_feeder #(
  parameter int A_H     = 16,
  parameter int B_W     = 16,
  parameter int WIDTH   = 8,
  parameter int KW      = 16,
  parameter int ARR_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_H*WIDTH-1:0] in_a,
  input  logic [B_W*WIDTH-1:0] in_b,
  output logic [A_H*WIDTH-1:0] a_out,
  output logic [B_W*WIDTH-1:0] b_out,
  output logic                 clc,
  output logic                 busy,
  output logic                 done
);

  // Zeros must travel the deepest skew lane plus the array pipeline.
  localparam int FLUSH_LEN = A_H + B_W - 2 + ARR_LAT;
  localparam int FW        = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [KW-1:0]        k_len_reg;
  logic [KW-1:0]        beat_cnt_reg;
  logic [KW-1:0]        beat_inc;
  logic [FW-1:0]        flush_cnt_reg;
  logic                 accept;
  logic [A_H*WIDTH-1:0] feed_a;
  logic [B_W*WIDTH-1:0] feed_b;

  assign in_ready = (state_reg == S_FEED);
  assign clc      = (state_reg == S_CLEAR);
  assign done     = (state_reg == S_DONE);
  assign busy     = (state_reg != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign beat_inc = beat_cnt_reg + KW'(1);

  // A non-accepting cycle pushes a zero bubble so lane alignment is kept.
  assign feed_a = accept ? in_a : '0;
  assign feed_b = accept ? in_b : '0;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:  if (start && (k_len != '0)) state_next = S_CLEAR;
      S_CLEAR: state_next = S_FEED;
      S_FEED:  if (accept && (beat_inc == k_len_reg)) state_next = S_FLUSH;
      S_FLUSH: if (flush_cnt_reg == FLUSH_LAST) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_IDLE) && start && (k_len != '0)) k_len_reg <= k_len;
      if (state_reg == S_CLEAR) beat_cnt_reg <= '0;
      else if (accept)          beat_cnt_reg <= beat_inc;
      if (state_reg == S_FLUSH) flush_cnt_reg <= flush_cnt_reg + FW'(1);
      else                      flush_cnt_reg <= '0;
    end
  end

  // Lane n sees n line stages plus its output register: n+1 cycles total.
  genvar gi;
  generate
    for (gi = 0; gi < A_H; gi++) begin : g_a
      logic [WIDTH-1:0] out_reg;
      assign a_out[gi*WIDTH +: WIDTH] = out_reg;
      if (gi == 0) begin : g_direct
        always_ff @(posedge clk) begin
          if (rst) out_reg <= '0;
          else     out_reg <= feed_a[gi*WIDTH +: WIDTH];
        end
      end else begin : g_line
        logic [WIDTH-1:0] line_reg [gi];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int k = 0; k < gi; k++) line_reg[k] <= '0;
            out_reg <= '0;
          end else begin
            line_reg[0] <= feed_a[gi*WIDTH +: WIDTH];
            for (int k = 1; k < gi; k++) line_reg[k] <= line_reg[k-1];
            out_reg <= line_reg[gi-1];
          end
        end
      end
    end

    for (gi = 0; gi < B_W; gi++) begin : g_b
      logic [WIDTH-1:0] out_reg;
      assign b_out[gi*WIDTH +: WIDTH] = out_reg;
      if (gi == 0) begin : g_direct
        always_ff @(posedge clk) begin
          if (rst) out_reg <= '0;
          else     out_reg <= feed_b[gi*WIDTH +: WIDTH];
        end
      end else begin : g_line
        logic [WIDTH-1:0] line_reg [gi];
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int k = 0; k < gi; k++) line_reg[k] <= '0;
            out_reg <= '0;
          end else begin
            line_reg[0] <= feed_b[gi*WIDTH +: WIDTH];
            for (int k = 1; k < gi; k++) line_reg[k] <= line_reg[k-1];
            out_reg <= line_reg[gi-1];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_os_array_feeder.sv
// Directed bench for os_array_feeder (4x4 array, 8-bit lanes, flush of 8 cycles):
// per-cycle vector tables plus hand sequences for bubble, restart and reset cases.
module tb_os_array_feeder;
  localparam int A_H = 4, B_W = 4, WIDTH = 8, KW = 16, ARR_LAT = 2;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, clc, busy, done;
  logic [KW-1:0] k_len;
  logic [31:0] in_a, in_b, a_out, b_out;

  always #5 clk = ~clk;

  os_array_feeder #(
    .A_H(A_H), .B_W(B_W), .WIDTH(WIDTH), .KW(KW), .ARR_LAT(ARR_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .a_out(a_out), .b_out(b_out), .clc(clc), .busy(busy), .done(done)
  );

  typedef struct {
    logic        r, s;
    logic [15:0] kl;
    logic        v;
    logic [31:0] a, b;
    logic        e_clc, e_rdy, e_busy, e_done;
    logic [31:0] e_a, e_b;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] rep(input logic [7:0] x);
    return {4{x}};
  endfunction

  function automatic void add(input logic s, input logic [15:0] kl, input logic [31:0] a, b,
                              input logic e_clc, e_rdy, e_busy, e_done,
                              input logic [31:0] e_a, e_b);
    tbl.push_back('{1'b0, s, kl, 1'b1, a, b, e_clc, e_rdy, e_busy, e_done, e_a, e_b});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_clc, e_rdy, e_busy, e_done,
                         input logic [31:0] e_a, e_b);
    chk({tag, ".clc"},      32'(clc),      32'(e_clc));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
    chk({tag, ".done"},     32'(done),     32'(e_done));
    chk({tag, ".a_out"},    a_out,         e_a);
    chk({tag, ".b_out"},    b_out,         e_b);
  endtask

  // One call = one cycle: drive just after the rising edge, sample at the falling edge.
  task automatic step(input logic r, s, input logic [15:0] kl, input logic v,
                      input logic [31:0] a, b);
    @(posedge clk);
    #1;
    rst = r; start = s; k_len = kl; in_valid = v; in_a = a; in_b = b;
    @(negedge clk);
  endtask

  logic [7:0] acc [0:16];
  function automatic logic [7:0] acc_at(input int c);
    return (c < 0) ? 8'h00 : acc[c];
  endfunction

  initial begin
    int clc_cnt, done_cnt, done_at, clc_at;
    logic [7:0] bv;
    logic v, e_rdy;
    logic [31:0] e_vec;

    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;

    // Tile k_len=3, beats 1,2,3 in every lane; filler 0x55 must never leak through.
    for (int c = 0; c < 15; c++) begin
      bv = (c == 2) ? 8'h01 : (c == 3) ? 8'h02 : (c == 4) ? 8'h03 : 8'h55;
      case (c)
        0:       add(1, 3, rep(bv), rep(bv), 0, 0, 0, 0, 32'h0, 32'h0);
        1:       add(0, 3, rep(bv), rep(bv), 1, 0, 1, 0, 32'h0, 32'h0);
        2:       add(0, 3, rep(bv), rep(bv), 0, 1, 1, 0, 32'h0, 32'h0);
        3:       add(0, 3, rep(bv), rep(bv), 0, 1, 1, 0, 32'h00000001, 32'h00000001);
        4:       add(0, 3, rep(bv), rep(bv), 0, 1, 1, 0, 32'h00000102, 32'h00000102);
        5:       add(0, 3, rep(bv), rep(bv), 0, 0, 1, 0, 32'h00010203, 32'h00010203);
        6:       add(0, 3, rep(bv), rep(bv), 0, 0, 1, 0, 32'h01020300, 32'h01020300);
        7:       add(0, 3, rep(bv), rep(bv), 0, 0, 1, 0, 32'h02030000, 32'h02030000);
        8:       add(0, 3, rep(bv), rep(bv), 0, 0, 1, 0, 32'h03000000, 32'h03000000);
        13:      add(0, 3, rep(bv), rep(bv), 0, 0, 1, 1, 32'h0, 32'h0);
        14:      add(0, 3, rep(bv), rep(bv), 0, 0, 0, 0, 32'h0, 32'h0);
        default: add(0, 3, rep(bv), rep(bv), 0, 0, 1, 0, 32'h0, 32'h0);
      endcase
    end
    // Single beat with distinct lanes, including negative A values.
    for (int c = 0; c < 13; c++) begin
      case (c)
        0:       add(1, 1, 32'h83828180, 32'h04030201, 0, 0, 0, 0, 32'h0, 32'h0);
        1:       add(0, 1, 32'h83828180, 32'h04030201, 1, 0, 1, 0, 32'h0, 32'h0);
        2:       add(0, 1, 32'h83828180, 32'h04030201, 0, 1, 1, 0, 32'h0, 32'h0);
        3:       add(0, 1, 32'h83828180, 32'h04030201, 0, 0, 1, 0, 32'h00000080, 32'h00000001);
        4:       add(0, 1, 32'h83828180, 32'h04030201, 0, 0, 1, 0, 32'h00008100, 32'h00000200);
        5:       add(0, 1, 32'h83828180, 32'h04030201, 0, 0, 1, 0, 32'h00820000, 32'h00030000);
        6:       add(0, 1, 32'h83828180, 32'h04030201, 0, 0, 1, 0, 32'h83000000, 32'h04000000);
        11:      add(0, 1, 32'h83828180, 32'h04030201, 0, 0, 1, 1, 32'h0, 32'h0);
        12:      add(0, 1, 32'h83828180, 32'h04030201, 0, 0, 0, 0, 32'h0, 32'h0);
        default: add(0, 1, 32'h83828180, 32'h04030201, 0, 0, 1, 0, 32'h0, 32'h0);
      endcase
    end

    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_all("reset", 0, 0, 0, 0, 32'h0, 32'h0);
    $display("reset: outputs idle");

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].kl, tbl[i].v, tbl[i].a, tbl[i].b);
      chk_all($sformatf("vec%0d", i), tbl[i].e_clc, tbl[i].e_rdy, tbl[i].e_busy,
              tbl[i].e_done, tbl[i].e_a, tbl[i].e_b);
      $display("vec %0d: clc=%0b rdy=%0b busy=%0b done=%0b a_out=%h b_out=%h",
               i, clc, in_ready, busy, done, a_out, b_out);
    end

    // Zero-length start is ignored.
    step(0, 1, 0, 1, rep(8'h11), rep(8'h11));
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 1, rep(8'h11), rep(8'h11));
      chk_all($sformatf("klen0_c%0d", c), 0, 0, 0, 0, 32'h0, 32'h0);
    end
    $display("klen0: start ignored");

    // Bubble at cycle 3: accepts stretch to cycle 5, done moves to cycle 14.
    for (int c = 0; c < 17; c++) begin
      v     = (c != 3);
      bv    = (c == 2) ? 8'h01 : (c == 3) ? 8'h77 : (c == 4) ? 8'h02 : (c == 5) ? 8'h03 : 8'h55;
      e_rdy = (c >= 2) && (c <= 5);
      step(0, c == 0, 3, v, rep(bv), rep(bv));
      e_vec = {acc_at(c - 4), acc_at(c - 3), acc_at(c - 2), acc_at(c - 1)};
      chk($sformatf("bubble_c%0d.in_ready", c), 32'(in_ready), 32'(e_rdy));
      chk($sformatf("bubble_c%0d.done", c), 32'(done), 32'(c == 14));
      chk($sformatf("bubble_c%0d.busy", c), 32'(busy), 32'((c >= 1) && (c <= 14)));
      chk($sformatf("bubble_c%0d.a_out", c), a_out, e_vec);
      chk($sformatf("bubble_c%0d.b_out", c), b_out, e_vec);
      acc[c] = (e_rdy && v) ? bv : 8'h00;
    end
    $display("bubble: tile complete");

    // Second start mid-tile (with a different k_len) changes nothing.
    clc_cnt = 0; done_cnt = 0; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      step(0, (c == 0) || (c == 5), (c == 5) ? 16'd7 : 16'd3, 1, rep(8'h11), rep(8'h22));
      if (clc) clc_cnt++;
      if (done) begin done_cnt++; done_at = c; end
    end
    chk("restart.clc_count", 32'(clc_cnt), 32'd1);
    chk("restart.done_count", 32'(done_cnt), 32'd1);
    chk("restart.done_cycle", 32'(done_at), 32'd13);
    $display("restart: done at cycle %0d", done_at);

    // Reset in the middle of FEED aborts the tile.
    for (int c = 0; c < 6; c++) begin
      step(c == 4, c == 0, 3, 1, rep(8'h33), rep(8'h44));
    end
    chk_all("abort_c5", 0, 0, 0, 0, 32'h0, 32'h0);
    done_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step(0, 0, 3, 1, rep(8'h33), rep(8'h44));
      if (done || clc || busy) done_cnt++;
    end
    chk("abort.activity_after", 32'(done_cnt), 32'd0);
    clc_at = -1; done_at = -1; done_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      step(0, c == 0, 3, 1, rep(8'h33), rep(8'h44));
      if (clc) clc_at = c;
      if (done) begin done_cnt++; done_at = c; end
    end
    chk("abort.fresh_clc_cycle", 32'(clc_at), 32'd1);
    chk("abort.fresh_done_cycle", 32'(done_at), 32'd13);
    chk("abort.fresh_done_count", 32'(done_cnt), 32'd1);
    $display("abort: fresh tile done at cycle %0d", done_at);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/os_array_feeder.md
OS_ARRAY_FEEDER -- requirements
Module: os_array_feeder

Interface
REQ-001 Parameter A_H, default 16, number of array rows (A lanes).
REQ-002 Parameter B_W, default 16, number of array columns (B lanes).
REQ-003 Parameter WIDTH, default 8, signed operand width.
REQ-004 Parameter KW, default 16, width of the reduction-length field.
REQ-005 Parameter ARR_LAT, default 2, array latency from A/B port to accumulator update.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  tile-start request, sampled only in IDLE.
REQ-009 k_len  input  KW  reduction length (beats) for the tile, latched on accepted start.
REQ-010 in_valid  input  1  operand beat valid.
REQ-011 in_ready  output  1  feeder accepts a beat this cycle.
REQ-012 in_a  input  A_H*WIDTH  one A column, lane i at bits [WIDTH*(i+1)-1:WIDTH*i].
REQ-013 in_b  input  B_W*WIDTH  one B row, lane j at bits [WIDTH*(j+1)-1:WIDTH*j].
REQ-014 a_out  output  A_H*WIDTH  skewed A vector to array A port, registered.
REQ-015 b_out  output  B_W*WIDTH  skewed B vector to array B port, registered.
REQ-016 clc  output  1  result-cache clear to array, registered.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse: array results final.

Function
REQ-019 States IDLE, CLEAR, FEED, FLUSH, DONE; state register only, outputs derived from registered state/datapath.
REQ-020 IDLE: start=1 and k_len!=0 -> latch k_len, next CLEAR; start=1 with k_len=0 -> ignored, stay IDLE, no done.
REQ-021 start while busy is ignored; latched k_len is not altered.
REQ-022 CLEAR lasts exactly 1 cycle with clc=1; clc=0 in every other state; next FEED.
REQ-023 in_ready=1 only in FEED; beat accepted when in_valid and in_ready both 1.
REQ-024 Beat counter (KW bits) clears on entering FEED, increments per accepted beat; the accept making count equal k_len moves to FLUSH next cycle.
REQ-025 FEED cycle with in_valid=0: zero vector enters all skew lanes (bubble); alignment preserved.
REQ-026 Skew: a_out lane i = in_a lane i of the beat entering the skew line i+1 cycles earlier; b_out lane j likewise delayed j+1 cycles; lane 0 delay 1 (output register only).
REQ-027 Outside FEED the skew-line input is zero; FLUSH shifts zeros for A_H+B_W-2+ARR_LAT cycles, then DONE.
REQ-028 DONE lasts 1 cycle, done=1, busy=1, next IDLE.
REQ-029 Data passed unmodified (no sign extension, no arithmetic); skew lines are WIDTH-bit shift registers, depth A_H-1 (A) and B_W-1 (B).
REQ-030 Total start-sampled-to-done = 1 (CLEAR) + FEED cycles + (A_H+B_W-2+ARR_LAT) + 1.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, counters 0, all skew registers 0, a_out=0, b_out=0, clc=0, busy=0, done=0, in_ready=0.
REQ-032 rst mid-tile aborts it: no done pulse, no clc, latched k_len discarded; next tile requires new start.

Verification (A_H=B_W=4, WIDTH=8, ARR_LAT=2, flush=8 cycles)
REQ-033 start, k_len=3 at cycle 0, in_valid constant 1, beats a=b=all lanes {1,2,3} -> clc=1 cycle 1, in_ready cycles 2-4, done cycle 13 only; a_out lane 3 = 1,2,3 at cycles 6,7,8.
REQ-034 Same tile with in_valid=0 at cycle 3 -> in_ready held through cycle 5, zero bubble in every lane one slot, done cycle 14.
REQ-035 start with k_len=0 -> busy stays 0, clc never asserted, no done.
REQ-036 start pulsed at cycles 0 and 5 of one tile -> single CLEAR, single done, k_len unchanged.
REQ-037 rst=1 at cycle 4 of REQ-033 tile -> cycle 5: all outputs 0, IDLE, no done thereafter; fresh start then completes normally.
REQ-038 in_b lane j = j+1, in_a lane i = 0x80+i, k_len=1 -> a_out lane i = 0x80+i exactly at cycle 3+i, b_out lane j = j+1 at cycle 3+j, zeros otherwise (signed values unaltered).
